// File: rtl/gf180mcu_osu_sc_9t_dlat_rf.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_dlat_rf
//
// Latch-based register file with DEPTH rows of WIDTH bits, for dense scratch
// storage. Each bit is stored in a level-sensitive D-latch. The write address
// and write data are captured in flops on posedge CLK. The selected row latch
// is transparent while CLK is low, then closes on the next rising edge. Read
// data is registered. After reset, or when CLR is requested, a clear sequencer
// writes zeros into every row, one row per cycle.
//
// Ports
//   CLK     in   1      single clock; flops on posedge, row latches open while low
//   RST     in   1      synchronous active-high reset
//   CLR     in   1      request a full-array clear (taken only when idle)
//   WE      in   1      write valid
//   WREADY  out  1      write ready; a write is taken on posedge when WE && WREADY
//   WADDR   in   AW     write row (rows >= DEPTH are accepted and dropped)
//   WDATA   in   WIDTH  write data
//   RADDR   in   AW     read row, sampled every posedge (rows >= DEPTH read 0)
//   RDATA   out  WIDTH  registered read data
//   BUSY    out  1      clear sequence in progress
//
// Build option
//   DLAT_RF_BYPASS_EN  When defined, a read of the row being written at the same
//                      edge returns WDATA. A same-edge read of the row being
//                      cleared returns 0. When undefined, there is no forwarding
//                      logic, and a same-edge read returns the old row contents.
//
// FSM states
//   state    | meaning
//   ST_IDLE  | accepting writes, CLR may start a clear
//   ST_CLEAR | zeroing row cnt_q each cycle, writes refused
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_9t_dlat_rf #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             WE,
  output logic             WREADY,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR,
  output logic [WIDTH-1:0] RDATA,
  output logic             BUSY
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;

  // Write staging flops: these drive the latch enables and the latch data.
  logic                 wv_q, wv_d;
  logic [AW-1:0]        wa_q, wa_d;
  logic [WIDTH-1:0]     wd_q, wd_d;

  logic [WIDTH-1:0]     rdata_d;
  logic [WIDTH-1:0]     rd_row;
  logic                 wr_take;

  logic [DEPTH-1:0]            row_en;
  logic [DEPTH-1:0][WIDTH-1:0] rows;

  assign WREADY  = (state_q == ST_IDLE) && !CLR;
  assign BUSY    = (state_q == ST_CLEAR);
  assign wr_take = WE && WREADY;

  // Next-state logic, and selection of the write source (user write or clear).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wv_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (WE) begin
          wv_d = 1'b1;
          wa_d = WADDR;
          wd_d = WDATA;
        end
      end
      ST_CLEAR: begin
        // The clear uses the normal write path, with zero data.
        wv_d = 1'b1;
        wa_d = cnt_q;
        wd_d = '0;
        if (cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Read mux. Rows that do not exist read as zero.
  always_comb begin
    rd_row = '0;
    if ({1'b0, RADDR} < DEPTH_X) begin
      rd_row = rows[RADDR];
    end
  end

  always_comb begin
    rdata_d = rd_row;
`ifdef DLAT_RF_BYPASS_EN
    if (wr_take && (RADDR == WADDR) && ({1'b0, RADDR} < DEPTH_X)) begin
      rdata_d = WDATA;
    end else if ((state_q == ST_CLEAR) && (RADDR == cnt_q)) begin
      rdata_d = '0;
    end
`endif
  end

  // On reset, the staging flops keep a zero write pending for row 0. Row 0
  // is therefore scrubbed on every cycle that RST is held, and any write that
  // was in flight is dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      wv_q    <= 1'b1;
      wa_q    <= '0;
      wd_q    <= '0;
      RDATA   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wv_q    <= wv_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      RDATA   <= rdata_d;
    end
  end

  // Row storage. The enables are built only from CLK and flopped terms, so
  // each enable is stable while CLK is low and drops cleanly at the rising edge.
  for (genvar r = 0; r < DEPTH; r++) begin : g_row
    logic [WIDTH-1:0] row_q;

    assign row_en[r] = ~CLK & wv_q & (wa_q == AW'(r));

    always_latch begin
      if (row_en[r]) begin
        row_q <= wd_q;
      end
    end

    assign rows[r] = row_q;
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_dlat_rf.sv
module tb_gf180mcu_osu_sc_9t_dlat_rf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;

  // DUT A: default build, DEPTH=16.
  logic       clr = 1'b0, we = 1'b0;
  logic [3:0] waddr = '0, raddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       wready, busy;

  // DUT B: DEPTH=10, used to cover out-of-range rows.
  logic       b_clr = 1'b0, b_we = 1'b0;
  logic [3:0] b_waddr = '0, b_raddr = '0;
  logic [7:0] b_wdata = '0;
  logic [7:0] b_rdata;
  logic       b_wready, b_busy;

  gf180mcu_osu_sc_9t_dlat_rf #(.WIDTH(8), .DEPTH(16)) u_dut_a (
    .CLK(clk), .RST(rst), .CLR(clr), .WE(we), .WREADY(wready),
    .WADDR(waddr), .WDATA(wdata), .RADDR(raddr), .RDATA(rdata), .BUSY(busy)
  );

  gf180mcu_osu_sc_9t_dlat_rf #(.WIDTH(8), .DEPTH(10)) u_dut_b (
    .CLK(clk), .RST(rst), .CLR(b_clr), .WE(b_we), .WREADY(b_wready),
    .WADDR(b_waddr), .WDATA(b_wdata), .RADDR(b_raddr), .RDATA(b_rdata), .BUSY(b_busy)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t        sb_a[$];
  sb_t        sb_b[$];
  logic [7:0] model_a [16];
  logic [7:0] model_b [10];
  bit         rd_a = 1'b0, rd_b = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 16; i++) model_a[i] = 8'h00;
    for (int i = 0; i < 10; i++) model_b[i] = 8'h00;
  endtask

  // One clock cycle. Before the edge, push the expected read data into the
  // scoreboard. After the edge, pop it and compare it, then commit any writes
  // accepted at this edge to the model.
  task automatic tick();
    sb_t e;
    bit  acc_a, acc_b;
    int  ia, ib;
    acc_a = we && !clr;
    acc_b = b_we && !b_clr;
    ia = int'(raddr);
    ib = int'(b_raddr);
    if (rd_a) begin
      e.tag = $sformatf("rd_a[%0d]", ia);
      e.exp = model_a[ia];
`ifdef DLAT_RF_BYPASS_EN
      if (acc_a && waddr == raddr) e.exp = wdata;
`endif
      sb_a.push_back(e);
    end
    if (rd_b) begin
      e.tag = $sformatf("rd_b[%0d]", ib);
      e.exp = (ib < 10) ? model_b[ib % 10] : 8'h00;
`ifdef DLAT_RF_BYPASS_EN
      if (acc_b && b_waddr == b_raddr && ib < 10) e.exp = b_wdata;
`endif
      sb_b.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rd_a) begin
      e = sb_a.pop_front();
      chk(e.tag, rdata, e.exp);
    end
    if (rd_b) begin
      e = sb_b.pop_front();
      chk(e.tag, b_rdata, e.exp);
    end
    if (acc_a) model_a[int'(waddr)] = wdata;
    if (acc_b && int'(b_waddr) < 10) model_b[int'(b_waddr) % 10] = b_wdata;
    rd_a  = 1'b0;
    rd_b  = 1'b0;
    we    = 1'b0;
    b_we  = 1'b0;
    clr   = 1'b0;
    b_clr = 1'b0;
  endtask

  // Count the cycles until BUSY drops, with a bound. WREADY must stay low
  // while BUSY is high. Optionally pulse CLR on DUT A during the clear.
  task automatic wait_clear(input int exp_a, input int exp_b, input bit pulse_clr);
    int na, nb;
    bit da, db;
    na = 0; nb = 0;
    da = 1'b0;
    db = (exp_b < 0);
    for (int i = 1; i <= 64 && !(da && db); i++) begin
      if (pulse_clr && i >= 3 && i <= 6) clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      if (!da && !busy) begin da = 1'b1; na = i; end
      if (!db && !b_busy) begin db = 1'b1; nb = i; end
      if (!da) chk("clear_wready_a", wready, 1'b0);
    end
    chk("busy_cycles_a", na, exp_a);
    if (exp_b >= 0) chk("busy_cycles_b", nb, exp_b);
  endtask

  task automatic read_all_a();
    for (int r = 0; r < 16; r++) begin
      raddr = 4'(r);
      rd_a  = 1'b1;
      tick();
    end
  endtask

  initial begin
    // Hold reset for 3 cycles, then release it and wait for the clear to finish.
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b1);
      chk("rst_wready", wready, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
    end
    rst = 1'b0;
    wait_clear(16, 10, 1'b0);
    zero_models();
    chk("idle_wready_a", wready, 1'b1);
    chk("idle_wready_b", b_wready, 1'b1);
    read_all_a();

    // Write row 3, then read it at the same edge and at the following edge.
    we = 1'b1; waddr = 4'd3; wdata = 8'hA5; raddr = 4'd3; rd_a = 1'b1;
    tick();
    raddr = 4'd3; rd_a = 1'b1;
    tick();

    // Write every row at full rate, reading back the row written one cycle earlier.
    for (int r = 0; r < 16; r++) begin
      we = 1'b1; waddr = 4'(r); wdata = 8'(8'h10 + r);
      if (r > 0) begin
        raddr = 4'(r - 1);
        rd_a  = 1'b1;
      end
      tick();
    end
    read_all_a();

    // Assert CLR and WE together: CLR wins, and the whole array is cleared.
    clr = 1'b1; we = 1'b1; waddr = 4'd5; wdata = 8'hFF;
    #1;
    chk("clr_we_wready", wready, 1'b0);
    tick();
    chk("clr_busy", busy, 1'b1);
    wait_clear(16, -1, 1'b0);
    zero_models();
    read_all_a();

    // Reset in the middle of a clear (cnt=7). CLR pulses during the clear are ignored.
    we = 1'b1; waddr = 4'd9; wdata = 8'h77;
    tick();
    clr = 1'b1;
    tick();
    chk("clr2_busy", busy, 1'b1);
    repeat (7) tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b1);
    wait_clear(16, 10, 1'b1);
    zero_models();
    read_all_a();

    // DEPTH=10: a write to row 12 is accepted and dropped, and row 12 reads as 0.
    for (int r = 0; r < 10; r++) begin
      b_we = 1'b1; b_waddr = 4'(r); b_wdata = 8'(8'h50 + r);
      tick();
    end
    b_we = 1'b1; b_waddr = 4'd12; b_wdata = 8'h3C;
    #1;
    chk("oor_wready_b", b_wready, 1'b1);
    tick();
    for (int r = 0; r < 10; r++) begin
      b_raddr = 4'(r);
      rd_b    = 1'b1;
      tick();
    end
    b_raddr = 4'd12; rd_b = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
